// File: rtl/carfield_secd_dmi_preload_ctrl_if.sv
// Section/data stream and DMI request/response bundle for the secure-domain preload sequencer.
// The master modport is the sequencer side; slave is the loader/debug-module side.
interface carfield_secd_dmi_preload_ctrl_if #(
  parameter int unsigned LenW = 16
) ();
  logic            sec_valid_i;
  logic            sec_ready_o;
  logic [31:0]     sec_addr_i;
  logic [LenW-1:0] sec_len_i;
  logic            sec_last_i;

  logic            data_valid_i;
  logic            data_ready_o;
  logic [31:0]     data_i;

  logic            dmi_req_valid_o;
  logic            dmi_req_ready_i;
  logic [6:0]      dmi_req_addr_o;
  logic [1:0]      dmi_req_op_o;
  logic [31:0]     dmi_req_data_o;
  logic            dmi_resp_valid_i;
  logic            dmi_resp_ready_o;
  logic [31:0]     dmi_resp_data_i;
  logic [1:0]      dmi_resp_resp_i;

  modport master (
    input  sec_valid_i, sec_addr_i, sec_len_i, sec_last_i,
    output sec_ready_o,
    input  data_valid_i, data_i,
    output data_ready_o,
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    input  dmi_req_ready_i,
    input  dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    output dmi_resp_ready_o
  );

  modport slave (
    output sec_valid_i, sec_addr_i, sec_len_i, sec_last_i,
    input  sec_ready_o,
    output data_valid_i, data_i,
    input  data_ready_o,
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    output dmi_req_ready_i,
    output dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    input  dmi_resp_ready_o
  );
endinterface

// File: rtl/carfield_secd_dmi_preload_ctrl.sv
// Hardware preload/boot sequencer for the security island: SBA-writes sections, sets DPC, resumes the core.
// Optional CARFIELD_SECD_PRELOAD_CHECKSUM_EN adds checksum_o over all accepted data words.
module carfield_secd_dmi_preload_ctrl #(
  parameter int unsigned LenW        = 16,
  parameter int unsigned PollTimeout = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] entry_addr_i,
  carfield_secd_dmi_preload_ctrl_if.master bus,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  localparam logic [6:0] AddrDmControl = 7'h10;
  localparam logic [6:0] AddrDmStatus  = 7'h11;
  localparam logic [6:0] AddrData0     = 7'h04;
  localparam logic [6:0] AddrCommand   = 7'h17;
  localparam logic [6:0] AddrSbcs      = 7'h38;
  localparam logic [6:0] AddrSbAddr0   = 7'h39;
  localparam logic [6:0] AddrSbData0   = 7'h3C;
  localparam logic [1:0] OpRead        = 2'd1;
  localparam logic [1:0] OpWrite       = 2'd2;

  localparam int unsigned     PollW    = $clog2(PollTimeout + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(PollTimeout - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_ACT_WR, S_ACT_POLL, S_CFG_WR, S_CFG_POLL, S_SEC_WAIT,
    S_ADDR_WR, S_ADDR_POLL, S_DATA, S_DATA_WR, S_DATA_POLL,
    S_WAKE_DATA0, S_WAKE_HALTREQ, S_HALT_POLL, S_HALTREQ_CLR, S_CMD,
    S_RESUMEREQ, S_RESUME_CLR, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic             op_pend_q;
  logic [31:0]      entry_q, sec_addr_q, wdata_q;
  logic [LenW-1:0]  rem_q;
  logic             last_q;
  logic [PollW-1:0] poll_cnt_q;
  logic             done_q, error_q;
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
  logic [31:0]      checksum_q;
`endif

  logic        op_active;
  logic [6:0]  op_addr;
  logic [1:0]  op_kind;
  logic [31:0] op_data;
  logic        resp_fire, req_fire, sec_fire, data_fire;
  logic        sb_busy, sb_err, halted, poll_timeout;
  logic        sb_fail, sb_done, halt_fail;
  logic        unused_resp_bits;

  assign req_fire  = bus.dmi_req_valid_o & bus.dmi_req_ready_i;
  assign resp_fire = op_pend_q & bus.dmi_resp_valid_i;
  assign sec_fire  = bus.sec_valid_i & bus.sec_ready_o;
  assign data_fire = bus.data_valid_i & bus.data_ready_o;

  assign sb_busy      = bus.dmi_resp_data_i[21];
  assign sb_err       = |bus.dmi_resp_data_i[14:12];
  assign halted       = bus.dmi_resp_data_i[8];
  assign poll_timeout = (poll_cnt_q == PollLast);
  assign sb_fail      = sb_err | (sb_busy & poll_timeout);
  assign sb_done      = ~sb_busy & ~sb_err;
  assign halt_fail    = ~halted & poll_timeout;

  assign unused_resp_bits = ^{bus.dmi_resp_data_i[31:22], bus.dmi_resp_data_i[20:15],
                              bus.dmi_resp_data_i[11:9], bus.dmi_resp_data_i[7:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:         if (start_i) state_d = S_ACT_WR;
      S_ACT_WR:       if (resp_fire) state_d = S_ACT_POLL;
      S_ACT_POLL:     if (resp_fire) state_d = sb_fail ? S_ERROR : (sb_done ? S_CFG_WR : S_ACT_POLL);
      S_CFG_WR:       if (resp_fire) state_d = S_CFG_POLL;
      S_CFG_POLL:     if (resp_fire) state_d = sb_fail ? S_ERROR : (sb_done ? S_SEC_WAIT : S_CFG_POLL);
      S_SEC_WAIT: begin
        if (sec_fire) begin
          if (bus.sec_len_i != '0) state_d = S_ADDR_WR;
          else if (bus.sec_last_i) state_d = S_WAKE_DATA0;
        end
      end
      S_ADDR_WR:      if (resp_fire) state_d = S_ADDR_POLL;
      S_ADDR_POLL:    if (resp_fire) state_d = sb_fail ? S_ERROR : (sb_done ? S_DATA : S_ADDR_POLL);
      S_DATA:         if (data_fire) state_d = S_DATA_WR;
      S_DATA_WR:      if (resp_fire) state_d = S_DATA_POLL;
      S_DATA_POLL: begin
        if (resp_fire) begin
          if (sb_fail)           state_d = S_ERROR;
          else if (!sb_done)     state_d = S_DATA_POLL;
          else if (rem_q != '0)  state_d = S_DATA;
          else                   state_d = last_q ? S_WAKE_DATA0 : S_SEC_WAIT;
        end
      end
      S_WAKE_DATA0:   if (resp_fire) state_d = S_WAKE_HALTREQ;
      S_WAKE_HALTREQ: if (resp_fire) state_d = S_HALT_POLL;
      S_HALT_POLL:    if (resp_fire) state_d = halt_fail ? S_ERROR : (halted ? S_HALTREQ_CLR : S_HALT_POLL);
      S_HALTREQ_CLR:  if (resp_fire) state_d = S_CMD;
      S_CMD:          if (resp_fire) state_d = S_RESUMEREQ;
      S_RESUMEREQ:    if (resp_fire) state_d = S_RESUME_CLR;
      S_RESUME_CLR:   if (resp_fire) state_d = S_DONE;
      S_DONE, S_ERROR: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
    // A failing response code overrides whatever the per-state decode chose.
    if (resp_fire && (bus.dmi_resp_resp_i != 2'd0)) state_d = S_ERROR;
  end

  always_comb begin
    op_active = 1'b1;
    op_addr   = '0;
    op_kind   = '0;
    op_data   = '0;
    unique case (state_q)
      S_ACT_WR:       begin op_addr = AddrDmControl; op_kind = OpWrite; op_data = 32'h0000_0001; end
      S_ACT_POLL, S_CFG_POLL, S_ADDR_POLL, S_DATA_POLL:
                      begin op_addr = AddrSbcs;      op_kind = OpRead;  end
      S_CFG_WR:       begin op_addr = AddrSbcs;      op_kind = OpWrite; op_data = 32'h0005_8000; end
      S_ADDR_WR:      begin op_addr = AddrSbAddr0;   op_kind = OpWrite; op_data = sec_addr_q; end
      S_DATA_WR:      begin op_addr = AddrSbData0;   op_kind = OpWrite; op_data = wdata_q; end
      S_WAKE_DATA0:   begin op_addr = AddrData0;     op_kind = OpWrite; op_data = entry_q; end
      S_WAKE_HALTREQ: begin op_addr = AddrDmControl; op_kind = OpWrite; op_data = 32'h8000_0001; end
      S_HALT_POLL:    begin op_addr = AddrDmStatus;  op_kind = OpRead;  end
      S_HALTREQ_CLR:  begin op_addr = AddrDmControl; op_kind = OpWrite; op_data = 32'h0000_0001; end
      S_CMD:          begin op_addr = AddrCommand;   op_kind = OpWrite; op_data = 32'h0023_07B1; end
      S_RESUMEREQ:    begin op_addr = AddrDmControl; op_kind = OpWrite; op_data = 32'h4000_0001; end
      S_RESUME_CLR:   begin op_addr = AddrDmControl; op_kind = OpWrite; op_data = 32'h0000_0001; end
      default:        op_active = 1'b0;
    endcase

    bus.dmi_req_valid_o  = op_active & ~op_pend_q;
    bus.dmi_req_addr_o   = op_addr;
    bus.dmi_req_op_o     = op_kind;
    bus.dmi_req_data_o   = op_data;
    bus.dmi_resp_ready_o = op_pend_q;
    bus.sec_ready_o      = (state_q == S_SEC_WAIT);
    bus.data_ready_o     = (state_q == S_DATA);
    busy_o               = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    done_o               = done_q;
    error_o              = error_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_pend_q  <= 1'b0;
      entry_q    <= '0;
      sec_addr_q <= '0;
      wdata_q    <= '0;
      rem_q      <= '0;
      last_q     <= 1'b0;
      poll_cnt_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      if (req_fire)       op_pend_q <= 1'b1;
      else if (resp_fire) op_pend_q <= 1'b0;

      if (state_q == S_IDLE && start_i) begin
        entry_q <= entry_addr_i;
        done_q  <= 1'b0;
        error_q <= 1'b0;
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
        checksum_q <= '0;
`endif
      end

      if (sec_fire) begin
        sec_addr_q <= bus.sec_addr_i;
        rem_q      <= bus.sec_len_i;
        last_q     <= bus.sec_last_i;
      end

      if (data_fire) begin
        wdata_q <= bus.data_i;
        rem_q   <= rem_q - 1'b1;
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
        checksum_q <= {checksum_q[30:0], checksum_q[31]} ^ bus.data_i;
`endif
      end

      // Poll budget restarts whenever the FSM moves on; only repeated reads in one state consume it.
      if (state_d != state_q) poll_cnt_q <= '0;
      else if (resp_fire)     poll_cnt_q <= poll_cnt_q + 1'b1;

      if (state_d == S_DONE)  done_q  <= 1'b1;
      if (state_d == S_ERROR) error_q <= 1'b1;
    end
  end

`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_carfield_secd_dmi_preload_ctrl.sv
// Directed bench for carfield_secd_dmi_preload_ctrl with a behavioural DMI/debug-module responder.
// Build with CARFIELD_SECD_PRELOAD_CHECKSUM_EN defined to also check checksum_o.
module tb_carfield_secd_dmi_preload_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] entry_addr = '0;
  logic        busy, done, error;
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  carfield_secd_dmi_preload_ctrl_if #(.LenW(16)) bus ();

  carfield_secd_dmi_preload_ctrl #(.LenW(16), .PollTimeout(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .entry_addr_i (entry_addr),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
    ,
    .checksum_o   (checksum)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- DMI responder ----------------
  logic [40:0] log_q[$];
  logic [40:0] exp_q[$];
  int  sb_busy_after_wr = 0;
  int  sb_busy_left     = 0;
  bit  halt_ok          = 1'b1;
  bit  err_on_addr      = 1'b0;
  bit  op_out           = 1'b0;

  initial begin
    logic [6:0]  a;
    logic [1:0]  o;
    logic [31:0] d, rd;
    logic [1:0]  rr;
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_resp_data_i  = '0;
    bus.dmi_resp_resp_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dmi_req_valid_o) begin
        a = bus.dmi_req_addr_o;
        o = bus.dmi_req_op_o;
        d = (o == 2'd2) ? bus.dmi_req_data_o : 32'h0;
        log_q.push_back({a, o, d});
        op_out = 1'b1;
        bus.dmi_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.dmi_req_ready_i = 1'b0;
        rd = '0;
        rr = '0;
        if (o == 2'd1 && a == 7'h38) begin
          rd = 32'h0004_0000;
          if (sb_busy_left > 0) begin
            rd = rd | 32'h0020_0000;
            sb_busy_left--;
          end
        end
        if (o == 2'd1 && a == 7'h11) rd = halt_ok ? 32'h0000_0382 : 32'h0000_0082;
        if (o == 2'd2 && a == 7'h3C) sb_busy_left = sb_busy_after_wr;
        if (o == 2'd2 && a == 7'h39 && err_on_addr) rr = 2'd2;
        @(negedge clk);
        bus.dmi_resp_valid_i = 1'b1;
        bus.dmi_resp_data_i  = rd;
        bus.dmi_resp_resp_i  = rr;
        @(posedge clk); #1;
        bus.dmi_resp_valid_i = 1'b0;
        bus.dmi_resp_data_i  = '0;
        bus.dmi_resp_resp_i  = '0;
        op_out = 1'b0;
      end
    end
  end

  always @(negedge clk) if (op_out && bus.data_ready_o) viol++;

  // ---------------- stream sources ----------------
  logic [48:0] sec_q[$];
  logic [31:0] dat_q[$];

  initial begin
    bus.sec_valid_i = 1'b0; bus.sec_addr_i = '0; bus.sec_len_i = '0; bus.sec_last_i = 1'b0;
    forever begin
      if (sec_q.size() == 0) begin
        bus.sec_valid_i = 1'b0;
        @(posedge clk); #1;
      end else begin
        bus.sec_valid_i = 1'b1;
        {bus.sec_addr_i, bus.sec_len_i, bus.sec_last_i} = sec_q[0];
        @(negedge clk);
        if (bus.sec_ready_o) begin
          @(posedge clk); #1;
          if (sec_q.size() != 0) void'(sec_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.data_valid_i = 1'b0; bus.data_i = '0;
    forever begin
      if (dat_q.size() == 0) begin
        bus.data_valid_i = 1'b0;
        @(posedge clk); #1;
      end else begin
        bus.data_valid_i = 1'b1;
        bus.data_i = dat_q[0];
        @(negedge clk);
        if (bus.data_ready_o) begin
          @(posedge clk); #1;
          if (dat_q.size() != 0) void'(dat_q.pop_front());
        end
      end
    end
  end

  // ---------------- expected op sequence builders ----------------
  function automatic void ew(input logic [6:0] a, input logic [31:0] d);
    exp_q.push_back({a, 2'd2, d});
  endfunction
  function automatic void er(input logic [6:0] a);
    exp_q.push_back({a, 2'd1, 32'h0});
  endfunction
  function automatic void e_prologue();
    ew(7'h10, 32'h1); er(7'h38); ew(7'h38, 32'h0005_8000); er(7'h38);
  endfunction
  function automatic void e_section(input logic [31:0] addr);
    ew(7'h39, addr); er(7'h38);
  endfunction
  function automatic void e_word(input logic [31:0] d, input int busy_reads);
    ew(7'h3C, d);
    for (int i = 0; i <= busy_reads; i++) er(7'h38);
  endfunction
  function automatic void e_wake(input logic [31:0] entry);
    ew(7'h04, entry); ew(7'h10, 32'h8000_0001); er(7'h11); ew(7'h10, 32'h1);
    ew(7'h17, 32'h0023_07B1); ew(7'h10, 32'h4000_0001); ew(7'h10, 32'h1);
  endfunction

  task automatic compare_log(input string tag);
    check($sformatf("%s op_count", tag), 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check($sformatf("%s op%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic setup(input int busy_reads, input bit halts, input bit addr_err);
    log_q.delete(); exp_q.delete();
    sb_busy_after_wr = busy_reads;
    sb_busy_left     = 0;
    halt_ok          = halts;
    err_on_addr      = addr_err;
  endtask

  logic err_at_start, done_at_start;

  task automatic run_seq(input logic [31:0] entry, input int restart_at, output bit timed_out);
    entry_addr = entry;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 0) begin err_at_start = error; done_at_start = done; end
      start_i = (i == restart_at);
      if (!busy && (done || error)) begin timed_out = 1'b0; break; end
    end
    start_i = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit to;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst req_valid", bus.dmi_req_valid_o, 0);
    check("rst ready", {bus.sec_ready_o, bus.data_ready_o, bus.dmi_resp_ready_o}, 0);
    check("rst req_fields", {bus.dmi_req_addr_o, bus.dmi_req_op_o, bus.dmi_req_data_o}, 0);
    rst_n = 1'b1;

    // single section, three words
    setup(0, 1, 0);
    sec_q.push_back({32'h1000_0000, 16'd3, 1'b1});
    dat_q.push_back(32'h8000_0001); dat_q.push_back(32'h0000_00F0); dat_q.push_back(32'h1234_5678);
    e_prologue(); e_section(32'h1000_0000);
    e_word(32'h8000_0001, 0); e_word(32'h0000_00F0, 0); e_word(32'h1234_5678, 0);
    e_wake(32'h1000_0000);
    run_seq(32'h1000_0000, -1, to);
    check("t1 timeout", to, 0);
    compare_log("t1");
    check("t1 done", done, 1);
    check("t1 error", error, 0);
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
    check("t1 checksum", checksum, 32'h1234_579E);
`endif

    // two sections, second empty and last
    setup(0, 1, 0);
    sec_q.push_back({32'h2000_0000, 16'd2, 1'b0});
    sec_q.push_back({32'h3000_0000, 16'd0, 1'b1});
    dat_q.push_back(32'h1); dat_q.push_back(32'h2);
    e_prologue(); e_section(32'h2000_0000);
    e_word(32'h1, 0); e_word(32'h2, 0);
    e_wake(32'h2000_0100);
    run_seq(32'h2000_0100, -1, to);
    check("t2 timeout", to, 0);
    check("t2 done_cleared_on_start", done_at_start, 0);
    compare_log("t2");
    check("t2 done", done, 1);
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
    check("t2 checksum", checksum, 32'h0);
`endif

    // sbbusy for 5 reads after each data write; extra start while busy
    setup(5, 1, 0);
    sec_q.push_back({32'h1000_0040, 16'd2, 1'b1});
    dat_q.push_back(32'hDEAD_BEEF); dat_q.push_back(32'h0BAD_F00D);
    e_prologue(); e_section(32'h1000_0040);
    e_word(32'hDEAD_BEEF, 5); e_word(32'h0BAD_F00D, 5);
    e_wake(32'h1000_0040);
    run_seq(32'h1000_0040, 20, to);
    check("t3 timeout", to, 0);
    compare_log("t3");
    check("t3 done", done, 1);
    check("t3 data_ready_during_op", viol, 0);

    // sbbusy never clears within the poll budget of 8
    setup(8, 1, 0);
    sec_q.push_back({32'h1000_0080, 16'd1, 1'b1});
    dat_q.push_back(32'h5);
    e_prologue(); e_section(32'h1000_0080); ew(7'h3C, 32'h5);
    for (int i = 0; i < 8; i++) er(7'h38);
    run_seq(32'h1000_0080, -1, to);
    check("t4 timeout", to, 0);
    compare_log("t4");
    check("t4 error", error, 1);
    check("t4 done", done, 0);

    // core never halts: exactly 8 DMStatus reads, no Command
    setup(0, 0, 0);
    sec_q.push_back({32'h1000_0000, 16'd1, 1'b1});
    dat_q.push_back(32'h7);
    e_prologue(); e_section(32'h1000_0000); e_word(32'h7, 0);
    ew(7'h04, 32'h1000_0000); ew(7'h10, 32'h8000_0001);
    for (int i = 0; i < 8; i++) er(7'h11);
    run_seq(32'h1000_0000, -1, to);
    check("t5 timeout", to, 0);
    compare_log("t5");
    check("t5 error", error, 1);
    check("t5 done", done, 0);

    // error response on SBAddress0 write, then clean restart
    setup(0, 1, 1);
    sec_q.push_back({32'h1000_0000, 16'd1, 1'b1});
    dat_q.push_back(32'h9);
    e_prologue(); ew(7'h39, 32'h1000_0000);
    run_seq(32'h1000_0000, -1, to);
    check("t6 timeout", to, 0);
    compare_log("t6");
    check("t6 error", error, 1);
    check("t6 done", done, 0);
    check("t6 busy", busy, 0);
    dat_q.delete();
    repeat (3) @(posedge clk);
    setup(0, 1, 0);
    sec_q.push_back({32'h4000_0000, 16'd1, 1'b1});
    dat_q.push_back(32'h11);
    e_prologue(); e_section(32'h4000_0000); e_word(32'h11, 0); e_wake(32'h4000_0000);
    run_seq(32'h4000_0000, -1, to);
    check("t7 timeout", to, 0);
    check("t7 error_cleared_on_start", err_at_start, 0);
    compare_log("t7");
    check("t7 done", done, 1);
    check("t7 error", error, 0);

    // asynchronous reset while in DATA
    setup(0, 1, 0);
    sec_q.push_back({32'h5000_0000, 16'd4, 1'b1});
    dat_q.push_back(32'hA); dat_q.push_back(32'hB); dat_q.push_back(32'hC); dat_q.push_back(32'hD);
    entry_addr = 32'h5000_0000;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.data_ready_o) begin seen = 1'b1; break; end
    end
    check("t8 reached_data", seen, 1);
    check("t8 busy_before_reset", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t8 busy", busy, 0);
    check("t8 flags", {done, error}, 0);
    check("t8 ready", {bus.sec_ready_o, bus.data_ready_o, bus.dmi_resp_ready_o}, 0);
    check("t8 req", {bus.dmi_req_valid_o, bus.dmi_req_addr_o, bus.dmi_req_op_o, bus.dmi_req_data_o}, 0);
`ifdef CARFIELD_SECD_PRELOAD_CHECKSUM_EN
    check("t8 checksum", checksum, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
